// File: rtl/ped_crossing_panel.sv
// Pedestrian crossing panel: synchronizes and debounces the push-button, requests the
// crossing from the controller and sequences the WALK / flashing DON'T WALK lamps.
module ped_crossing_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 20,
    parameter int unsigned FLASH_HALF      = 2,
    parameter int unsigned CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             PED_light,
    output logic             button,
    output logic             req_lamp,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [FL_W-1:0]  FLASH_LOAD = FL_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {StIdle, StWait, StWalk, StClear} state_e;

    state_e            state_q, state_d;
    logic              s1_q, s2_q;
    logic              db_q, db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              press_q, press_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [FL_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic              flash_q, flash_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= 1'b0;
            pending_q   <= 1'b0;
            timer_q     <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            s1_q        <= btn_raw;
            s2_q        <= s1_q;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (s2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = db_d & ~db_q;
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        timer_d     = timer_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        unique case (state_q)
            StIdle: begin
                pending_d = 1'b0;
                if (PED_light) begin
                    state_d = StWalk;
                    timer_d = WALK_LOAD;
                end else if (press_q || pending_q) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (PED_light) begin
                    state_d = StWalk;
                    timer_d = WALK_LOAD;
                end
            end
            StWalk: begin
                if (press_q) pending_d = 1'b1;
                if (!PED_light) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    state_d     = StClear;
                    flash_cnt_d = FLASH_LOAD;
                    flash_d     = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StClear: begin
                if (press_q) pending_d = 1'b1;
                if (!PED_light) begin
                    state_d = StIdle;
                end else if (flash_cnt_q == '0) begin
                    flash_cnt_d = FLASH_LOAD;
                    flash_d     = ~flash_q;
                end else begin
                    flash_cnt_d = flash_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        button    = (state_q == StWait);
        req_lamp  = (state_q == StWait) || pending_q;
        walk      = (state_q == StWalk);
        dont_walk = 1'b1;
        countdown = '0;
        if (state_q == StWalk) begin
            dont_walk = 1'b0;
            countdown = timer_q;
        end else if (state_q == StClear) begin
            dont_walk = flash_q;
        end
    end

endmodule

// File: tb/tb_ped_crossing_panel.sv
// Directed bench for ped_crossing_panel: expected output vectors are queued as stimulus is
// driven and compared one cycle later, 1 time unit after the rising edge.
module tb_ped_crossing_panel;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       PED_light;
    logic       button;
    logic       req_lamp;
    logic       walk;
    logic       dont_walk;
    logic [4:0] countdown;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];
    string      tag_q[$];

    // Output vector layout: {button, req_lamp, walk, dont_walk, countdown}
    localparam logic [8:0] IDLE_O = 9'b0_0_0_1_00000;
    localparam logic [8:0] WAIT_O = 9'b1_1_0_1_00000;

    ped_crossing_panel #(
        .DEBOUNCE_CYCLES(4),
        .WALK_CYCLES    (20),
        .FLASH_HALF     (2),
        .CNT_W          (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .PED_light(PED_light),
        .button   (button),
        .req_lamp (req_lamp),
        .walk     (walk),
        .dont_walk(dont_walk),
        .countdown(countdown)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] walk_o(input logic req, input int n);
        logic [4:0] c;
        c = 5'(n);
        return {1'b0, req, 1'b1, 1'b0, c};
    endfunction

    function automatic logic [8:0] clear_o(input logic dw);
        return {1'b0, 1'b0, 1'b0, dw, 5'd0};
    endfunction

    task automatic compare_front();
        logic [8:0] exp_v;
        logic [8:0] obs_v;
        string      tag;
        exp_v = sb_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {button, req_lamp, walk, dont_walk, countdown};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed btn/req/walk/dw/cd=%b expected %b", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_now(input logic [8:0] e, input string tag);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        compare_front();
    endtask

    // Expectation queued now, compared after the next rising edge.
    task automatic step(input logic [8:0] e, input string tag);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        reset     = 1'b0;
        btn_raw   = 1'b1;
        PED_light = 1'b0;
        @(posedge clk);
        #1;
        check_now(IDLE_O, "reset_btn_high");
        step(IDLE_O, "reset_held");
        reset = 1'b1;

        // Button held since before edge 0: request appears after edge 6.
        for (int e = 0; e <= 5; e++) step(IDLE_O, $sformatf("press_lat_e%0d", e));
        step(WAIT_O, "press_lat_e6");
        step(WAIT_O, "wait_hold");

        btn_raw   = 1'b0;
        PED_light = 1'b1;
        for (int n = 19; n >= 0; n--) step(walk_o(1'b0, n), $sformatf("walk_cd%0d", n));
        step(clear_o(1'b1), "clear_f0");
        step(clear_o(1'b1), "clear_f1");
        step(clear_o(1'b0), "clear_f2");
        step(clear_o(1'b0), "clear_f3");
        step(clear_o(1'b1), "clear_f4");
        step(clear_o(1'b1), "clear_f5");
        PED_light = 1'b0;
        for (int i = 0; i < 3; i++) step(IDLE_O, $sformatf("release_idle%0d", i));

        // Glitch shorter than the debounce window.
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) step(IDLE_O, $sformatf("glitch_hi%0d", i));
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) step(IDLE_O, $sformatf("glitch_lo%0d", i));

        // 5-cycle pulse is long enough.
        btn_raw = 1'b1;
        for (int e = 0; e <= 4; e++) step(IDLE_O, $sformatf("pulse5_e%0d", e));
        btn_raw = 1'b0;
        step(IDLE_O, "pulse5_e5");
        step(WAIT_O, "pulse5_e6");
        for (int i = 0; i < 4; i++) step(WAIT_O, $sformatf("pulse5_wait%0d", i));

        // Press during WALK raises only the WAIT lamp; IDLE then forwards it.
        PED_light = 1'b1;
        step(walk_o(1'b0, 19), "grant2");
        btn_raw = 1'b1;
        for (int k = 0; k < 12; k++)
            step(walk_o(k >= 6, 18 - k), $sformatf("walk_press_k%0d", k));
        btn_raw   = 1'b0;
        PED_light = 1'b0;
        step(9'b0_1_0_1_00000, "pending_idle");
        step(WAIT_O, "pending_wait");
        for (int i = 0; i < 6; i++) step(WAIT_O, $sformatf("pending_wait%0d", i));

        // Reset mid-WALK at countdown 7 with a pending request.
        PED_light = 1'b1;
        step(walk_o(1'b0, 19), "grant3");
        btn_raw = 1'b1;
        for (int k = 0; k < 12; k++)
            step(walk_o(k >= 6, 18 - k), $sformatf("walk_rst_k%0d", k));
        reset     = 1'b0;
        btn_raw   = 1'b0;
        PED_light = 1'b0;
        #1;
        check_now(IDLE_O, "async_reset");
        step(IDLE_O, "reset_low");
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step(IDLE_O, $sformatf("post_reset%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
